cursor_tracker: RTL and testbench
=================================

// Module: cursor_tracker
// PURPOSE
//  Accumulates PS/2 mouse movement packets into the cursor position consumed by the
//  cursor-overlay colour stage. Positions are in 0.1-pixel units (pixel = pos/10) on a 640x480 screen.
//  Sits between the PS/2 mouse packet decoder (upstream) and the overlay/colour mux (downstream).
//  The displayed position is double-buffered and updates only at frame_start, so the cursor never tears mid-frame.
// PARAMETERS
//  H_MAX   6390  largest h_position (pixel 639 * 10)
//  V_MAX   4790  largest v_position (pixel 479 * 10)
//  H_INIT  3200  h_position after reset
//  V_INIT  2400  v_position after reset
//  GAIN    10    position units per mouse count (10 = 1 pixel per count); 1..31
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  pkt_valid    in   1   movement packet available
//  pkt_ready    out  1   block can accept a packet
//  dx           in   9   signed X delta, two's complement, +right
//  dy           in   9   signed Y delta, two's complement, +up (PS/2 convention)
//  ovf_x        in   1   X overflow flag from packet
//  ovf_y        in   1   Y overflow flag from packet
//  btn_left     in   1   left-button state from packet
//  frame_start  in   1   1-cycle pulse at start of vertical blanking
//  h_position   out  14  displayed X position, 0..H_MAX
//  v_position   out  14  displayed Y position, 0..V_MAX
//  click_pulse  out  1   1-cycle pulse on left-button press
//  btn_hold     out  1   registered left-button state
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, work_h=H_INIT, work_v=V_INIT, h_position=H_INIT,
//    v_position=V_INIT, click_pulse=0, btn_hold=0. pkt_ready=1 once reset deasserts.
//  - FSM IDLE -> SCALE -> ACCUM -> IDLE. pkt_ready = (state==IDLE), decoded from state.
//  - IDLE: on pkt_valid&&pkt_ready capture dx,dy,ovf_x,ovf_y,btn_left; go SCALE.
//  - SCALE: ovf_x set -> dx forced to +255 if dx[8]==0 else -256; same for Y.
//    sdx = dx*GAIN, sdy = -(dy*GAIN), signed 16-bit, registered. Go ACCUM.
//  - ACCUM: work_h = clamp(work_h + sdx, 0, H_MAX); work_v = clamp(work_v + sdy, 0, V_MAX),
//    sums evaluated in signed 17 bit; negative -> 0, above max -> max. Go IDLE.
//    click_pulse=1 in ACCUM cycle iff captured btn_left==1 and btn_hold==0; btn_hold <= captured btn_left.
//  - Latency: accept at cycle 0, work regs updated at end of cycle 2, pkt_ready high again cycle 3.
//    Max throughput 1 packet / 3 cycles; pkt_valid held while busy is not consumed.
//  - frame_start: h_position<=work_h, v_position<=work_v (register values at start of that cycle).
//    frame_start coincident with ACCUM: displayed gets pre-ACCUM work value; new value at next frame_start.
//  - Between frame_start pulses outputs are stable regardless of packets.
//  - dx=dy=0 packet: positions unchanged, button logic still evaluated.
// STRUCTURE
//  - Package cursor_pkg: H_MAX/V_MAX/H_INIT/V_INIT defaults, state enum {IDLE,SCALE,ACCUM},
//    position width constant (14).
//  - Sub-module sat_accum (signed add + clamp to [0,MAX]), instantiated for X and Y.
//  - Top: FSM, capture regs, scaling, button edge detect, frame-synced shadow regs.
// TESTING
//  1. Reset, no packets, frame_start -> h_position=3200, v_position=2400; pkt_ready=1.
//  2. dx=+5, dy=0, then frame_start -> h_position=3250, v_position=2400; before frame_start still 3200.
//  3. From h=100: dx=-255 -> h clamps to 0; from v=50: dy=+10 -> v=0; from h=6300: dx=+20 -> 6390.
//  4. ovf_x=1,dx=9'h001 -> +2550 applied; frame_start in same cycle as ACCUM -> old value shown,
//     new value after next frame_start.
//  5. pkt_valid held 6 cycles, dx=+1 -> exactly 2 packets accepted (cycles 0,3), h=+20 units;
//     pkt_ready low cycles 1-2 and 4-5.
//  6. btn_left 0,1,1,0,1 over 5 packets -> click_pulse on packets 2 and 5 only; rst_n low during
//     SCALE -> immediate IDLE, outputs 3200/2400, click_pulse=0.

Source files
------------

// File: rtl/cursor_pkg.sv
// Shared constants, FSM state type and overflow helper for the PS/2 cursor tracker.
// Positions are in 0.1-pixel units on a 640x480 screen.
package cursor_pkg;

  localparam int POS_W      = 14;
  localparam int H_MAX_DEF  = 6390;
  localparam int V_MAX_DEF  = 4790;
  localparam int H_INIT_DEF = 3200;
  localparam int V_INIT_DEF = 2400;
  localparam int GAIN_DEF   = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCALE = 2'd1,
    ACCUM = 2'd2
  } state_t;

  // An overflowed axis saturates to the largest count in the direction of its sign bit.
  function automatic logic signed [8:0] force_ovf(input logic signed [8:0] d, input logic ovf);
    if (ovf) begin
      return d[8] ? 9'h100 : 9'h0FF;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/cursor_tracker_if.sv
// Movement-packet handshake between the PS/2 packet decoder (master) and the tracker (slave).
interface cursor_tracker_if;

  logic              pkt_valid;
  logic              pkt_ready;
  logic signed [8:0] dx;
  logic signed [8:0] dy;
  logic              ovf_x;
  logic              ovf_y;
  logic              btn_left;

  modport master (
    output pkt_valid, dx, dy, ovf_x, ovf_y, btn_left,
    input  pkt_ready
  );

  modport slave (
    input  pkt_valid, dx, dy, ovf_x, ovf_y, btn_left,
    output pkt_ready
  );

endinterface

// File: rtl/cursor_tracker_sat_accum.sv
// Signed add of a scaled delta to an unsigned position, clamped to [0, MAX].
module sat_accum
  import cursor_pkg::*;
#(
  parameter int MAX = H_MAX_DEF
) (
  input  logic [POS_W-1:0]  cur,
  input  logic signed [15:0] delta,
  output logic [POS_W-1:0]  sum_out
);

  localparam logic signed [16:0] MAX_S = 17'(MAX);
  localparam logic [POS_W-1:0]   MAX_P = POS_W'(MAX);

  logic signed [16:0] sum_s;

  assign sum_s = $signed({3'b000, cur}) + $signed({delta[15], delta});

  // Clamp the 17-bit signed sum into the legal position range.
  always_comb begin
    sum_out = sum_s[POS_W-1:0];
    if (sum_s[16]) begin
      sum_out = {POS_W{1'b0}};
    end else if (sum_s > MAX_S) begin
      sum_out = MAX_P;
    end else begin
      sum_out = sum_s[POS_W-1:0];
    end
  end

endmodule

// File: rtl/cursor_tracker.sv
// Accumulates PS/2 movement packets into a working cursor position and publishes it
// to the overlay stage only at frame_start, so the displayed cursor never tears.
module cursor_tracker
  import cursor_pkg::*;
#(
  parameter int H_MAX  = H_MAX_DEF,
  parameter int V_MAX  = V_MAX_DEF,
  parameter int H_INIT = H_INIT_DEF,
  parameter int V_INIT = V_INIT_DEF,
  parameter int GAIN   = GAIN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  cursor_tracker_if.slave  pkt,
  input  logic             frame_start,
  output logic [POS_W-1:0] h_position,
  output logic [POS_W-1:0] v_position,
  output logic             click_pulse,
  output logic             btn_hold
);

  localparam logic signed [15:0] GAIN_S = 16'(GAIN);

  state_t              state_r, state_s;
  logic signed [8:0]   dx_r, dy_r;
  logic                ovf_x_r, ovf_y_r, btn_r;
  logic signed [8:0]   dx_eff_s, dy_eff_s;
  logic signed [15:0]  sdx_s, sdy_s, sdx_r, sdy_r;
  logic [POS_W-1:0]    work_h_r, work_v_r, nxt_h_s, nxt_v_s;

  assign pkt.pkt_ready = (state_r == IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic: one packet walks IDLE -> SCALE -> ACCUM -> IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pkt.pkt_valid) state_s = SCALE;
        else               state_s = IDLE;
      end
      SCALE:   state_s = ACCUM;
      ACCUM:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Capture the packet fields on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx_r <= 9'sd0; dy_r <= 9'sd0;
      ovf_x_r <= 1'b0; ovf_y_r <= 1'b0; btn_r <= 1'b0;
    end else if (state_r == IDLE && pkt.pkt_valid) begin
      dx_r <= pkt.dx; dy_r <= pkt.dy;
      ovf_x_r <= pkt.ovf_x; ovf_y_r <= pkt.ovf_y; btn_r <= pkt.btn_left;
    end
  end

  // Scale counts to position units; Y is negated because PS/2 +Y means up.
  always_comb begin
    dx_eff_s = force_ovf(dx_r, ovf_x_r);
    dy_eff_s = force_ovf(dy_r, ovf_y_r);
    sdx_s    = $signed({{7{dx_eff_s[8]}}, dx_eff_s}) * GAIN_S;
    sdy_s    = 16'sd0 - ($signed({{7{dy_eff_s[8]}}, dy_eff_s}) * GAIN_S);
  end

  // Scaled-delta registers loaded in SCALE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdx_r <= 16'sd0; sdy_r <= 16'sd0;
    end else if (state_r == SCALE) begin
      sdx_r <= sdx_s; sdy_r <= sdy_s;
    end
  end

  sat_accum #(.MAX(H_MAX)) u_acc_h (.cur(work_h_r), .delta(sdx_r), .sum_out(nxt_h_s));
  sat_accum #(.MAX(V_MAX)) u_acc_v (.cur(work_v_r), .delta(sdy_r), .sum_out(nxt_v_s));

  // Working position updated in ACCUM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_h_r <= POS_W'(H_INIT); work_v_r <= POS_W'(V_INIT);
    end else if (state_r == ACCUM) begin
      work_h_r <= nxt_h_s; work_v_r <= nxt_v_s;
    end
  end

  // Press detect registered in SCALE so the pulse coincides with the ACCUM cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      click_pulse <= 1'b0; btn_hold <= 1'b0;
    end else begin
      click_pulse <= (state_r == SCALE) && btn_r && !btn_hold;
      if (state_r == ACCUM) btn_hold <= btn_r;
    end
  end

  // Displayed shadow copies the working position only at frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_position <= POS_W'(H_INIT); v_position <= POS_W'(V_INIT);
    end else if (frame_start) begin
      h_position <= work_h_r; v_position <= work_v_r;
    end
  end

endmodule

// File: tb/tb_cursor_tracker.sv
// Randomized scoreboard bench for cursor_tracker with a cycle-level behavioural model.
module tb_cursor_tracker;

  localparam int GAIN = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [13:0] h_position, v_position;
  logic        click_pulse, btn_hold;

  cursor_tracker_if pif();

  cursor_tracker dut (
    .clk(clk), .rst_n(rst_n), .pkt(pif), .frame_start(frame_start),
    .h_position(h_position), .v_position(v_position),
    .click_pulse(click_pulse), .btn_hold(btn_hold)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m_h = 3200, m_v = 2400, m_hold = 0, phase = 0;
  int c_dx, c_dy, c_ox, c_oy, c_btn;
  int eh_q[$], ev_q[$];
  int click_q[$];
  int last_h = 3200, last_v = 2400;
  int dut_accepts = 0;
  bit rand_fs = 1'b0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff(int d, int ovf);
    if (ovf != 0) return (d < 0) ? -256 : 255;
    return d;
  endfunction

  function automatic int clampi(int x, int hi);
    if (x < 0) return 0;
    if (x > hi) return hi;
    return x;
  endfunction

  // Model: each packet takes three cycles; display samples work at start of frame cycle.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_h = 3200; m_v = 2400; m_hold = 0; phase = 0;
      eh_q.delete(); ev_q.delete(); click_q.delete();
      last_h = 3200; last_v = 2400;
    end else begin
      if (pif.pkt_valid && pif.pkt_ready) dut_accepts++;
      if (frame_start) begin
        eh_q.push_back(m_h);
        ev_q.push_back(m_v);
      end
      if (phase == 2) begin
        m_h = clampi(m_h + eff(c_dx, c_ox) * GAIN, 6390);
        m_v = clampi(m_v - eff(c_dy, c_oy) * GAIN, 4790);
        phase = 0;
      end else if (phase == 1) begin
        click_q.push_back((c_btn != 0 && m_hold == 0) ? 1 : 0);
        m_hold = c_btn;
        phase = 2;
      end else if (pif.pkt_valid) begin
        c_dx = int'(pif.dx); c_dy = int'(pif.dy);
        c_ox = int'(pif.ovf_x); c_oy = int'(pif.ovf_y); c_btn = int'(pif.btn_left);
        phase = 1;
      end
    end
  end

  // Monitor: compare DUT outputs against the model on every falling edge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("pkt_ready", int'(pif.pkt_ready), (phase == 0) ? 1 : 0);
      if (eh_q.size() > 0) begin
        last_h = eh_q.pop_front();
        last_v = ev_q.pop_front();
      end
      check("h_position", int'(h_position), last_h);
      check("v_position", int'(v_position), last_v);
      if (click_q.size() > 0) check("click_pulse", int'(click_pulse), click_q.pop_front());
      else                    check("click_idle", int'(click_pulse), 0);
      if (phase == 0) check("btn_hold", int'(btn_hold), m_hold);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    frame_start = rand_fs ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) cyc();
  endtask

  task automatic send(int dx, int dy, bit ox, bit oy, bit btn);
    bit taken = 1'b0;
    pif.dx = 9'(dx); pif.dy = 9'(dy);
    pif.ovf_x = ox; pif.ovf_y = oy; pif.btn_left = btn;
    pif.pkt_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      taken = pif.pkt_ready;
      cyc();
      if (taken) break;
    end
    pif.pkt_valid = 1'b0;
    if (!taken) check("accept_timeout", 0, 1);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    pif.pkt_valid = 1'b0; pif.dx = 9'sd0; pif.dy = 9'sd0;
    pif.ovf_x = 1'b0; pif.ovf_y = 1'b0; pif.btn_left = 1'b0;
    #12 rst_n = 1'b1;
    idle(2);

    // Reset state.
    check("reset_ready", int'(pif.pkt_ready), 1);
    frame();
    check("reset_h", int'(h_position), 3200);
    check("reset_v", int'(v_position), 2400);

    // Simple move, shown only after frame_start.
    send(5, 0, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("pre_frame_h", int'(h_position), 3200);
    frame();
    check("move_h", int'(h_position), 3250);
    check("move_v", int'(v_position), 2400);

    // Clamping at both ends of both axes.
    repeat (2) send(-255, 0, 1'b0, 1'b0, 1'b0);
    send(10, 0, 1'b0, 1'b0, 1'b0);
    send(-255, 0, 1'b0, 1'b0, 1'b0);
    idle(3); frame();
    check("clamp_h_low", int'(h_position), 0);
    send(0, 255, 1'b0, 1'b0, 1'b0);
    send(0, -5, 1'b0, 1'b0, 1'b0);
    send(0, 10, 1'b0, 1'b0, 1'b0);
    idle(3); frame();
    check("clamp_v_low", int'(v_position), 0);
    repeat (3) send(255, 0, 1'b0, 1'b0, 1'b0);
    send(-9, 0, 1'b0, 1'b0, 1'b0);
    send(20, 0, 1'b0, 1'b0, 1'b0);
    idle(3); frame();
    check("clamp_h_high", int'(h_position), 6390);

    // Overflow packet with frame_start coincident with ACCUM.
    rst_n = 1'b0; #2; rst_n = 1'b1;
    cyc();
    send(1, 0, 1'b1, 1'b0, 1'b0);
    cyc();
    frame_start = 1'b1;
    cyc();
    idle(1);
    check("ovf_old_shown", int'(h_position), 3200);
    frame();
    check("ovf_new_shown", int'(h_position), 5750);

    // Valid held for six cycles: two packets accepted.
    dut_accepts = 0;
    pif.dx = 9'sd1; pif.dy = 9'sd0; pif.ovf_x = 1'b0; pif.ovf_y = 1'b0; pif.btn_left = 1'b0;
    pif.pkt_valid = 1'b1;
    idle(6);
    pif.pkt_valid = 1'b0;
    idle(3);
    check("held_accepts", dut_accepts, 2);
    frame();
    check("held_h", int'(h_position), 5770);

    // Button edge detection over five packets.
    send(0, 0, 1'b0, 1'b0, 1'b0);
    send(0, 0, 1'b0, 1'b0, 1'b1);
    send(0, 0, 1'b0, 1'b0, 1'b1);
    send(0, 0, 1'b0, 1'b0, 1'b0);
    send(0, 0, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Reset while in SCALE.
    send(3, 3, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_scale_ready", int'(pif.pkt_ready), 1);
    check("rst_scale_h", int'(h_position), 3200);
    check("rst_scale_v", int'(v_position), 2400);
    check("rst_scale_click", int'(click_pulse), 0);
    #1 rst_n = 1'b1;
    idle(2);

    // Randomized packets with random frame_start pulses.
    rand_fs = 1'b1;
    repeat (60) begin
      send(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 3)));
    end
    rand_fs = 1'b0;
    idle(4);
    frame();
    idle(2);
    check("click_queue_drained", click_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
